// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one negedge-sampled single-port RAM between ports A and B.
// Define MEMORY_ARBITER_FIXED_PRIORITY_EN to make port A win every tie instead of alternating.
module memory_arbiter #(
   parameter logic RESET_LAST_GRANT = 1'b1
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_a_req,
   input  logic [29:0] i_a_address,
   input  logic [31:0] i_a_data_in,
   input  logic [3:0]  i_a_data_strobes,
   input  logic        i_a_write,
   output logic        o_a_done,
   output logic [31:0] o_a_data_out,
   input  logic        i_b_req,
   input  logic [29:0] i_b_address,
   input  logic [31:0] i_b_data_in,
   input  logic [3:0]  i_b_data_strobes,
   input  logic        i_b_write,
   output logic        o_b_done,
   output logic [31:0] o_b_data_out,
   output logic        o_mem_cs,
   output logic [29:0] o_mem_address,
   output logic [31:0] o_mem_data_out,
   output logic [3:0]  o_mem_data_strobes,
   output logic        o_mem_read,
   output logic        o_mem_write,
   input  logic [31:0] i_mem_data_in
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t      r_state;
   logic        r_last_grant;
   logic        r_winner;
   logic        r_mem_cs;
   logic [29:0] r_mem_address;
   logic [31:0] r_mem_data_out;
   logic [3:0]  r_mem_data_strobes;
   logic        r_mem_read;
   logic        r_mem_write;
   logic        r_a_done;
   logic        r_b_done;
   logic [31:0] r_a_data_out;
   logic [31:0] r_b_data_out;

   logic        w_any_req;
   logic        w_grant_b;
   logic [29:0] w_address;
   logic [31:0] w_data;
   logic [3:0]  w_strobes;
   logic        w_write;

   assign w_any_req = i_a_req | i_b_req;

   // Winner encoding matches last_grant: 0 = port A, 1 = port B.
   always_comb begin
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
      w_grant_b = i_b_req & ~i_a_req;
`else
      if (i_a_req && i_b_req)
         w_grant_b = ~r_last_grant;
      else
         w_grant_b = i_b_req;
`endif
   end

   assign w_address = w_grant_b ? i_b_address      : i_a_address;
   assign w_data    = w_grant_b ? i_b_data_in      : i_a_data_in;
   assign w_strobes = w_grant_b ? i_b_data_strobes : i_a_data_strobes;
   assign w_write   = w_grant_b ? i_b_write        : i_a_write;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state            <= IDLE;
         r_last_grant       <= RESET_LAST_GRANT;
         r_winner           <= 1'b0;
         r_mem_cs           <= 1'b0;
         r_mem_address      <= '0;
         r_mem_data_out     <= '0;
         r_mem_data_strobes <= '0;
         r_mem_read         <= 1'b0;
         r_mem_write        <= 1'b0;
         r_a_done           <= 1'b0;
         r_b_done           <= 1'b0;
         r_a_data_out       <= '0;
         r_b_data_out       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_a_done <= 1'b0;
               r_b_done <= 1'b0;
               if (w_any_req) begin
                  r_mem_cs           <= 1'b1;
                  r_mem_address      <= w_address;
                  r_mem_data_out     <= w_data;
                  r_mem_data_strobes <= w_strobes;
                  r_mem_read         <= ~w_write;
                  r_mem_write        <= w_write;
                  r_last_grant       <= w_grant_b;
                  r_winner           <= w_grant_b;
                  r_state            <= ACCESS;
               end
            end
            ACCESS: begin
               // Memory has acted on the mid-cycle negedge; read data is stable now.
               r_mem_cs    <= 1'b0;
               r_mem_read  <= 1'b0;
               r_mem_write <= 1'b0;
               if (r_winner) begin
                  r_b_done <= 1'b1;
                  if (r_mem_read)
                     r_b_data_out <= i_mem_data_in;
               end else begin
                  r_a_done <= 1'b1;
                  if (r_mem_read)
                     r_a_data_out <= i_mem_data_in;
               end
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_a_done           = r_a_done;
   assign o_a_data_out       = r_a_data_out;
   assign o_b_done           = r_b_done;
   assign o_b_data_out       = r_b_data_out;
   assign o_mem_cs           = r_mem_cs;
   assign o_mem_address      = r_mem_address;
   assign o_mem_data_out     = r_mem_data_out;
   assign o_mem_data_strobes = r_mem_data_strobes;
   assign o_mem_read         = r_mem_read;
   assign o_mem_write        = r_mem_write;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a negedge-sampled 512x32 RAM plus a
// transaction-level model of arbitration order and memory contents.
module tb_memory_arbiter;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        a_req = 1'b0, b_req = 1'b0;
   logic [29:0] a_address = '0, b_address = '0;
   logic [31:0] a_data_in = '0, b_data_in = '0;
   logic [3:0]  a_data_strobes = '0, b_data_strobes = '0;
   logic        a_write = 1'b0, b_write = 1'b0;
   logic        a_done, b_done;
   logic [31:0] a_data_out, b_data_out;
   logic        mem_cs, mem_read, mem_write;
   logic [29:0] mem_address;
   logic [31:0] mem_data_out;
   logic [3:0]  mem_data_strobes;
   logic [31:0] mem_data_in = '0;

   int checks = 0;
   int errors = 0;

   logic [31:0] ram       [0:511];
   logic [31:0] model_mem [0:511];
   logic [31:0] exp_a_out, exp_b_out;
   logic        model_last;
   bit          fixed_prio;

   always #5 clock = ~clock;

   memory_arbiter #(.RESET_LAST_GRANT(1'b1)) dut (
      .i_clock(clock), .i_reset_n(reset_n),
      .i_a_req(a_req), .i_a_address(a_address), .i_a_data_in(a_data_in),
      .i_a_data_strobes(a_data_strobes), .i_a_write(a_write),
      .o_a_done(a_done), .o_a_data_out(a_data_out),
      .i_b_req(b_req), .i_b_address(b_address), .i_b_data_in(b_data_in),
      .i_b_data_strobes(b_data_strobes), .i_b_write(b_write),
      .o_b_done(b_done), .o_b_data_out(b_data_out),
      .o_mem_cs(mem_cs), .o_mem_address(mem_address), .o_mem_data_out(mem_data_out),
      .o_mem_data_strobes(mem_data_strobes), .o_mem_read(mem_read), .o_mem_write(mem_write),
      .i_mem_data_in(mem_data_in)
   );

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old_w;
      for (int k = 0; k < 4; k++)
         if (strb[k]) r[8*k +: 8] = new_w[8*k +: 8];
      return r;
   endfunction

   // The RAM acts on the falling edge in the middle of the access cycle.
   always @(negedge clock) begin
      if (mem_cs === 1'b1) begin
         if (mem_write === 1'b1)
            ram[mem_address[8:0]] = merge(ram[mem_address[8:0]], mem_data_out, mem_data_strobes);
         if (mem_read === 1'b1)
            mem_data_in = ram[mem_address[8:0]];
      end
   end

   always @(negedge clock) begin
      if (reset_n === 1'b1) begin
         checks++;
         if ((a_done & b_done) === 1'b1) begin
            errors++;
            $display("FAIL done_exclusive: a_done=%b b_done=%b required not both 1", a_done, b_done);
         end
         checks++;
         if ((mem_read & mem_write) === 1'b1) begin
            errors++;
            $display("FAIL rw_exclusive: mem_read=%b mem_write=%b required not both 1", mem_read, mem_write);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      a_req = 1'b0;
      b_req = 1'b0;
      tick();
      reset_n = 1'b1;
      model_last = 1'b1;
      exp_a_out = '0;
      exp_b_out = '0;
   endtask

   task automatic wait_done(input bit port_b, output int cycles);
      cycles = -1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if ((port_b ? b_done : a_done) === 1'b1) begin
            cycles = c;
            return;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      checks++;
      if ({mem_cs, mem_read, mem_write, a_done, b_done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: cs/rd/wr/adone/bdone=%b required 00000",
                  {mem_cs, mem_read, mem_write, a_done, b_done});
      end
      checks++;
      if (mem_address !== '0 || mem_data_out !== '0 || mem_data_strobes !== '0 ||
          a_data_out !== '0 || b_data_out !== '0) begin
         errors++;
         $display("FAIL reset_data: addr=%h dout=%h strb=%h aout=%h bout=%h required all 0",
                  mem_address, mem_data_out, mem_data_strobes, a_data_out, b_data_out);
      end
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (mem_cs !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_cs: mem_cs=%b required 0", mem_cs);
         end
      end
      model_last = 1'b1;
      exp_a_out = '0;
      exp_b_out = '0;
   endtask

   task automatic test_a_read();
      ram[5] = 32'hDEADBEEF;
      model_mem[5] = 32'hDEADBEEF;
      a_address = 30'd5;
      a_write = 1'b0;
      a_data_in = $urandom;
      a_data_strobes = 4'hF;
      a_req = 1'b1;
      tick();
      checks++;
      if ({mem_cs, mem_read, mem_write} !== 3'b110 || mem_address !== 30'd5) begin
         errors++;
         $display("FAIL a_read_grant: cs/rd/wr=%b addr=%h required 110 addr 5",
                  {mem_cs, mem_read, mem_write}, mem_address);
      end
      tick();
      checks++;
      if (a_done !== 1'b1 || a_data_out !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL a_read_done: done=%b data=%h required 1 DEADBEEF", a_done, a_data_out);
      end
      checks++;
      if ({mem_cs, mem_read, mem_write} !== 3'b000 || mem_address !== 30'd5) begin
         errors++;
         $display("FAIL a_read_release: cs/rd/wr=%b addr=%h required 000 addr 5 held",
                  {mem_cs, mem_read, mem_write}, mem_address);
      end
      a_req = 1'b0;
      $display("txn port=A read addr=5 data=%h", a_data_out);
      tick();
      checks++;
      if (a_done !== 1'b0 || a_data_out !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL a_read_pulse: done=%b data=%h required 0 DEADBEEF held", a_done, a_data_out);
      end
      exp_a_out = 32'hDEADBEEF;
      model_last = 1'b0;
   endtask

   task automatic test_b_write();
      int cyc;
      ram[7] = '0;
      model_mem[7] = '0;
      b_address = 30'd7;
      b_data_in = 32'h0000AB00;
      b_data_strobes = 4'b0010;
      b_write = 1'b1;
      b_req = 1'b1;
      tick();
      checks++;
      if ({mem_cs, mem_read, mem_write} !== 3'b101 || mem_data_strobes !== 4'b0010 ||
          mem_data_out !== 32'h0000AB00 || mem_address !== 30'd7) begin
         errors++;
         $display("FAIL b_write_grant: cs/rd/wr=%b strb=%b data=%h addr=%h required 101 0010 0000AB00 7",
                  {mem_cs, mem_read, mem_write}, mem_data_strobes, mem_data_out, mem_address);
      end
      tick();
      checks++;
      if (b_done !== 1'b1 || b_data_out !== exp_b_out) begin
         errors++;
         $display("FAIL b_write_done: done=%b data_out=%h required 1 %h", b_done, b_data_out, exp_b_out);
      end
      b_req = 1'b0;
      model_mem[7] = merge(model_mem[7], 32'h0000AB00, 4'b0010);
      model_last = 1'b1;
      $display("txn port=B write addr=7 data=0000AB00 strb=0010");
      a_address = 30'd7;
      a_write = 1'b0;
      a_req = 1'b1;
      wait_done(1'b0, cyc);
      a_req = 1'b0;
      checks++;
      if (cyc !== 2 || a_data_out !== 32'h0000AB00) begin
         errors++;
         $display("FAIL b_write_readback: latency=%0d data=%h required 2 0000AB00", cyc, a_data_out);
      end
      $display("txn port=A read addr=7 data=%h", a_data_out);
      exp_a_out = model_mem[7];
      model_last = 1'b0;
      tick();
   endtask

   task automatic test_tie();
      bit exp_b;
      apply_reset();
      a_address = 30'd5; a_write = 1'b0;
      b_address = 30'd7; b_write = 1'b0;
      a_req = 1'b1;
      b_req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         exp_b = 1'b0;
         if (c % 2 == 0) begin
            exp_b = fixed_prio ? 1'b0 : ~model_last;
            model_last = exp_b;
         end
         checks++;
         if (a_done !== (c % 2 == 0 && !exp_b) || b_done !== (c % 2 == 0 && exp_b)) begin
            errors++;
            $display("FAIL tie_cycle%0d: a_done=%b b_done=%b required %b %b",
                     c, a_done, b_done, (c % 2 == 0 && !exp_b), (c % 2 == 0 && exp_b));
         end
         if (c % 2 == 0) begin
            $display("txn tie grant=%s cycle=%0d", exp_b ? "B" : "A", c);
            if (exp_b) exp_b_out = model_mem[7];
            else       exp_a_out = model_mem[5];
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_op();
      int cyc;
      apply_reset();
      ram[3] = 32'h55AA55AA;
      model_mem[3] = 32'h55AA55AA;
      a_address = 30'd3;
      a_data_in = 32'h12345678;
      a_data_strobes = 4'hF;
      a_write = 1'b1;
      a_req = 1'b1;
      tick();
      checks++;
      if ({mem_cs, mem_write} !== 2'b11) begin
         errors++;
         $display("FAIL midop_grant: cs/wr=%b required 11", {mem_cs, mem_write});
      end
      reset_n = 1'b0;
      a_req = 1'b0;
      #1;
      checks++;
      if ({mem_cs, mem_read, mem_write} !== 3'b000) begin
         errors++;
         $display("FAIL midop_async_clear: cs/rd/wr=%b required 000", {mem_cs, mem_read, mem_write});
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if ({a_done, b_done, mem_cs} !== 3'b000 || mem_address !== '0 || mem_data_out !== '0) begin
            errors++;
            $display("FAIL midop_no_done: adone/bdone/cs=%b addr=%h dout=%h required 000 0 0",
                     {a_done, b_done, mem_cs}, mem_address, mem_data_out);
         end
      end
      reset_n = 1'b1;
      model_last = 1'b1;
      exp_a_out = '0;
      exp_b_out = '0;
      a_write = 1'b0;
      a_req = 1'b1;
      wait_done(1'b0, cyc);
      a_req = 1'b0;
      checks++;
      if (cyc !== 2 || a_data_out !== model_mem[3]) begin
         errors++;
         $display("FAIL midop_word3: latency=%0d data=%h required 2 %h", cyc, a_data_out, model_mem[3]);
      end
      $display("txn port=A read addr=3 data=%h after aborted write", a_data_out);
      exp_a_out = model_mem[3];
      model_last = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      int addrs[6];
      int n_done;
      int last_cyc;
      for (int i = 16; i < 32; i++) begin
         ram[i] = $urandom;
         model_mem[i] = ram[i];
      end
      for (int i = 0; i < 6; i++) addrs[i] = $urandom_range(16, 31);
      n_done = 0;
      last_cyc = 0;
      a_write = 1'b0;
      a_address = 30'(addrs[0]);
      a_req = 1'b1;
      for (int cyc = 1; cyc <= 40 && n_done < 6; cyc++) begin
         tick();
         if (a_done === 1'b1) begin
            checks++;
            if (a_data_out !== model_mem[addrs[n_done]] || cyc - last_cyc != 2) begin
               errors++;
               $display("FAIL b2b_%0d: data=%h gap=%0d required %h gap 2",
                        n_done, a_data_out, cyc - last_cyc, model_mem[addrs[n_done]]);
            end
            $display("txn b2b port=A read addr=%0d data=%h cycle=%0d", addrs[n_done], a_data_out, cyc);
            exp_a_out = model_mem[addrs[n_done]];
            last_cyc = cyc;
            n_done++;
            if (n_done < 6) a_address = 30'(addrs[n_done]);
            else            a_req = 1'b0;
         end
      end
      a_req = 1'b0;
      checks++;
      if (n_done != 6) begin
         errors++;
         $display("FAIL b2b_count: completions=%0d required 6", n_done);
      end
      model_last = 1'b0;
      tick();
   endtask

   task automatic test_random();
      bit ra, rb, first_b, port_b, exp_port;
      logic [29:0] addr_a, addr_b;
      int seen, exp_count;
      apply_reset();
      for (int t = 0; t < 40; t++) begin
         ra = 1'($urandom_range(0, 1));
         rb = 1'($urandom_range(0, 1));
         if (!ra && !rb) ra = 1'b1;
         addr_a = 30'($urandom_range(0, 15));
         addr_b = 30'($urandom_range(0, 15));
         a_address = addr_a; a_data_in = $urandom; a_data_strobes = 4'($urandom_range(0, 15));
         a_write = 1'($urandom_range(0, 1));
         b_address = addr_b; b_data_in = $urandom; b_data_strobes = 4'($urandom_range(0, 15));
         b_write = 1'($urandom_range(0, 1));
         a_req = ra;
         b_req = rb;
         first_b = (ra && rb) ? (fixed_prio ? 1'b0 : ~model_last) : rb;
         exp_count = (ra && rb) ? 2 : 1;
         seen = 0;
         for (int c = 1; c <= 12 && seen < exp_count; c++) begin
            tick();
            if (a_done === 1'b1 || b_done === 1'b1) begin
               port_b = (b_done === 1'b1);
               exp_port = (seen == 0) ? first_b : ~first_b;
               if (port_b) begin
                  if (b_write) model_mem[addr_b[8:0]] = merge(model_mem[addr_b[8:0]], b_data_in, b_data_strobes);
                  else         exp_b_out = model_mem[addr_b[8:0]];
                  b_req = 1'b0;
               end else begin
                  if (a_write) model_mem[addr_a[8:0]] = merge(model_mem[addr_a[8:0]], a_data_in, a_data_strobes);
                  else         exp_a_out = model_mem[addr_a[8:0]];
                  a_req = 1'b0;
               end
               checks++;
               if (port_b !== exp_port || c != 2 * (seen + 1) ||
                   (port_b ? b_data_out : a_data_out) !== (port_b ? exp_b_out : exp_a_out)) begin
                  errors++;
                  $display("FAIL rand_%0d_%0d: port=%s cycle=%0d data=%h required port=%s cycle=%0d data=%h",
                           t, seen, port_b ? "B" : "A", c, port_b ? b_data_out : a_data_out,
                           exp_port ? "B" : "A", 2 * (seen + 1), port_b ? exp_b_out : exp_a_out);
               end
               $display("txn rand %0d port=%s %s addr=%0d data_out=%h", t, port_b ? "B" : "A",
                        (port_b ? b_write : a_write) ? "write" : "read",
                        port_b ? addr_b : addr_a, port_b ? b_data_out : a_data_out);
               model_last = port_b;
               seen++;
            end
         end
         a_req = 1'b0;
         b_req = 1'b0;
         checks++;
         if (seen != exp_count) begin
            errors++;
            $display("FAIL rand_%0d_timeout: completions=%0d required %0d", t, seen, exp_count);
         end
      end
   endtask

   initial begin
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
      fixed_prio = 1'b1;
`else
      fixed_prio = 1'b0;
`endif
      for (int i = 0; i < 512; i++) begin
         ram[i] = '0;
         model_mem[i] = '0;
      end
      #1 reset_n = 1'b0;
      test_reset();
      test_a_read();
      test_b_write();
      test_tie();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
